// File: rtl/matmul_tt_operand_feeder.sv
// matmul_tt_operand_feeder
// Holds A^T (K x M) and B^T (N x K) in two word-addressed buffers and
// streams the operand pairs of a transposed-both matmul. For every output
// element C[i][j] it sends the K pairs (A[i][k], B[k][j]) with k ascending.
// Loop order is i outer, j middle, k inner. out_last marks k = K-1.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ld_valid/ld_sel      load strobe; buffer select (0 = A^T, 1 = B^T)
//   ld_addr/ld_data      A^T address k*M+i, B^T address j*K+k; operand word
//   ld_drop              registered pulse: the previous load was rejected
//   start                starts a stream; honoured only in IDLE
//   busy, done           high while streaming; one-cycle pulse at the end
//   out_valid/out_ready  registered valid/ready output stage
//   data_a, data_b       A[i][k], B[k][j]
//   out_last             final pair of the current dot product
module matmul_tt_operand_feeder #(
    parameter int M  = 4,
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 32,
    parameter int AW = ((M * K) > (N * K)) ? (($clog2(M * K) > 0) ? $clog2(M * K) : 1)
                                           : (($clog2(N * K) > 0) ? $clog2(N * K) : 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_valid,
    input  logic          ld_sel,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_drop,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] data_a,
    output logic [DW-1:0] data_b,
    output logic          out_last
);
    localparam int IW  = (M > 1) ? $clog2(M) : 1;
    localparam int JW  = (N > 1) ? $clog2(N) : 1;
    localparam int KW  = (K > 1) ? $clog2(K) : 1;
    localparam int AAW = ((M * K) > 1) ? $clog2(M * K) : 1;
    localparam int BAW = ((N * K) > 1) ? $clog2(N * K) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(M - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r, state_nx_s;
    logic [IW-1:0]   i_r, i_nx_s;
    logic [JW-1:0]   j_r, j_nx_s;
    logic [KW-1:0]   k_r, k_nx_s;
    logic [DW-1:0]   a_buf_r [M*K];
    logic [DW-1:0]   b_buf_r [N*K];
    logic [AAW-1:0]  a_idx_s;
    logic [BAW-1:0]  b_idx_s;
    logic [DW-1:0]   a_rd_s, b_rd_s;
    logic            accept_s, final_s, ld_ok_s, a_in_range_s, b_in_range_s;
    logic            out_valid_r, valid_nx_s, out_last_r, last_nx_s;
    logic [DW-1:0]   data_a_r, a_nx_s, data_b_r, b_nx_s;
    logic            busy_r, busy_nx_s, done_r, done_nx_s, ld_drop_r, ld_drop_nx_s;

    assign accept_s = out_valid_r && out_ready;
    assign final_s  = accept_s && (i_r == I_LAST) && (j_r == J_LAST) && (k_r == K_LAST);

    assign a_in_range_s = (int'(ld_addr) < (M * K));
    assign b_in_range_s = (int'(ld_addr) < (N * K));
    assign ld_ok_s = ld_valid && (state_r == ST_IDLE) && !start &&
                     (ld_sel ? b_in_range_s : a_in_range_s);

    // Operand fetch for the beat about to be loaded into the output stage.
    assign a_idx_s = AAW'(int'(k_nx_s) * M + int'(i_nx_s));
    assign b_idx_s = BAW'(int'(j_nx_s) * K + int'(k_nx_s));
    assign a_rd_s  = a_buf_r[a_idx_s];
    assign b_rd_s  = b_buf_r[b_idx_s];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  state_nx_s = start ? ST_RUN : ST_IDLE;
            ST_RUN:   state_nx_s = final_s ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Beat coordinates: k fastest, then j, then i; held at zero outside RUN.
    always_comb begin
        i_nx_s = i_r;
        j_nx_s = j_r;
        k_nx_s = k_r;
        if (state_r != ST_RUN) begin
            i_nx_s = '0;
            j_nx_s = '0;
            k_nx_s = '0;
        end else if (accept_s) begin
            if (k_r == K_LAST) begin
                k_nx_s = '0;
                if (j_r == J_LAST) begin
                    j_nx_s = '0;
                    i_nx_s = (i_r == I_LAST) ? IW'(0) : (i_r + IW'(1));
                end else begin
                    j_nx_s = j_r + JW'(1);
                end
            end else begin
                k_nx_s = k_r + KW'(1);
            end
        end else begin
            i_nx_s = i_r;
        end
    end

    // Output-stage next values; data only changes when a new beat is loaded,
    // which keeps it stable under backpressure.
    always_comb begin
        valid_nx_s = out_valid_r;
        a_nx_s     = data_a_r;
        b_nx_s     = data_b_r;
        last_nx_s  = out_last_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    valid_nx_s = 1'b1;
                    a_nx_s     = a_rd_s;
                    b_nx_s     = b_rd_s;
                    last_nx_s  = (k_nx_s == K_LAST);
                end else begin
                    valid_nx_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (final_s) begin
                    valid_nx_s = 1'b0;
                end else if (accept_s) begin
                    valid_nx_s = 1'b1;
                    a_nx_s     = a_rd_s;
                    b_nx_s     = b_rd_s;
                    last_nx_s  = (k_nx_s == K_LAST);
                end else begin
                    valid_nx_s = out_valid_r;
                end
            end
            ST_DRAIN: valid_nx_s = 1'b0;
            default:  valid_nx_s = 1'b0;
        endcase
        busy_nx_s    = (state_nx_s == ST_RUN);
        done_nx_s    = (state_r == ST_DRAIN);
        ld_drop_nx_s = ld_valid && !ld_ok_s;
    end

    // Output stage, counters and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_r         <= '0;
            j_r         <= '0;
            k_r         <= '0;
            out_valid_r <= 1'b0;
            data_a_r    <= '0;
            data_b_r    <= '0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ld_drop_r   <= 1'b0;
        end else begin
            i_r         <= i_nx_s;
            j_r         <= j_nx_s;
            k_r         <= k_nx_s;
            out_valid_r <= valid_nx_s;
            data_a_r    <= a_nx_s;
            data_b_r    <= b_nx_s;
            out_last_r  <= last_nx_s;
            busy_r      <= busy_nx_s;
            done_r      <= done_nx_s;
            ld_drop_r   <= ld_drop_nx_s;
        end
    end

    // Operand buffers: written only by accepted loads, deliberately not reset.
    always_ff @(posedge clk) begin
        if (ld_ok_s && !ld_sel) begin
            a_buf_r[AAW'(ld_addr)] <= ld_data;
        end
        if (ld_ok_s && ld_sel) begin
            b_buf_r[BAW'(ld_addr)] <= ld_data;
        end
    end

    assign out_valid = out_valid_r;
    assign data_a    = data_a_r;
    assign data_b    = data_b_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign ld_drop   = ld_drop_r;

endmodule

// File: tb/tb_matmul_tt_operand_feeder.sv
// Self-checking bench: a 2x2x2 instance checked every cycle against an
// operand model and beat queue, plus a 2x2x1 instance checked inline.
module tb_matmul_tt_operand_feeder;
    localparam int MM = 2, NN = 2, KK = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid, ld_sel, start, out_ready;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_drop, busy, done, out_valid, out_last;
    logic [31:0] data_a, data_b;

    logic        k1_ld_valid, k1_ld_sel, k1_start, k1_out_ready;
    logic [0:0]  k1_ld_addr;
    logic [31:0] k1_ld_data;
    logic        k1_ld_drop, k1_busy, k1_done, k1_out_valid, k1_out_last;
    logic [31:0] k1_data_a, k1_data_b;

    always #5 clk = ~clk;

    matmul_tt_operand_feeder #(.M(MM), .N(NN), .K(KK), .DW(32), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_drop(ld_drop), .start(start),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .data_a(data_a), .data_b(data_b), .out_last(out_last)
    );

    matmul_tt_operand_feeder #(.M(2), .N(2), .K(1), .DW(32)) dut_k1 (
        .clk(clk), .rst_n(rst_n), .ld_valid(k1_ld_valid), .ld_sel(k1_ld_sel),
        .ld_addr(k1_ld_addr), .ld_data(k1_ld_data), .ld_drop(k1_ld_drop), .start(k1_start),
        .busy(k1_busy), .done(k1_done), .out_valid(k1_out_valid), .out_ready(k1_out_ready),
        .data_a(k1_data_a), .data_b(k1_data_b), .out_last(k1_out_last)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        l;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    a_m [8];
    int    b_m [8];
    beat_t exp_q [$];
    beat_t log_q [$];
    int    acc_cnt, last_cnt, done_cnt, busy_cnt, last_acc_cyc, done_cyc;
    logic  hold_v = 1'b0;
    beat_t hold_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected beats of one full run, straight from C[i][j] = sum_k A[i][k]*B[k][j].
    task automatic push_run();
        for (int i = 0; i < MM; i++)
            for (int j = 0; j < NN; j++)
                for (int k = 0; k < KK; k++)
                    exp_q.push_back('{a: 32'(a_m[k*MM+i]), b: 32'(b_m[j*KK+k]), l: (k == KK-1)});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare of the output stage against the expected beat queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_a", data_a, hold_b.a);
                chk("hold_b", data_b, hold_b.b);
                chk("hold_last", out_last, hold_b.l);
            end
            if (out_valid && out_ready) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("data_a", data_a, e.a);
                    chk("data_b", data_b, e.b);
                    chk("out_last", out_last, e.l);
                end
                log_q.push_back('{a: data_a, b: data_b, l: out_last});
                acc_cnt++;
                if (out_last) last_cnt++;
                last_acc_cyc = cyc;
            end
            hold_v = out_valid && !out_ready;
            hold_b = '{a: data_a, b: data_b, l: out_last};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cnt++;
        end
    end

    // Load with the bench deciding acceptance: IDLE, no start, address in range.
    task automatic load(input logic sel, input int addr, input int data);
        logic exp_drop;
        exp_drop = (addr >= (sel ? NN*KK : MM*KK));
        ld_valid = 1'b1; ld_sel = sel; ld_addr = 3'(addr); ld_data = 32'(data);
        step();
        ld_valid = 1'b0;
        chk("ld_drop", ld_drop, exp_drop);
        if (!exp_drop) begin
            if (sel) b_m[addr] = data;
            else     a_m[addr] = data;
        end
    endtask

    // mode: 0 ready high, 1 backpressure, 2 start spam, 3 load in RUN, 4 load with start
    task automatic run_stream(input int mode);
        int la [8] = '{0, 1, 0, 1, 10, 11, 10, 11};
        int lb [8] = '{0, 1, 100, 101, 0, 1, 100, 101};
        int n;
        push_run();
        log_q.delete();
        acc_cnt = 0; last_cnt = 0; done_cnt = 0; busy_cnt = 0;
        start = 1'b1; out_ready = 1'b1;
        if (mode == 4) begin
            ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 3'd1; ld_data = 32'd777;
        end
        step();
        chk("valid_latency", out_valid, 1);
        chk("busy_latency", busy, 1);
        start = (mode == 2);
        if (mode == 4) begin
            chk("ld_drop_with_start", ld_drop, 1);
            ld_valid = 1'b0;
        end
        if (mode == 3) begin
            ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 3'd0; ld_data = 32'd999;
            step();
            chk("ld_drop_in_run", ld_drop, 1);
            ld_valid = 1'b0;
        end
        n = 1;
        while (done_cnt == 0 && n < 100) begin
            out_ready = (mode == 1) ? ((n % 3) == 0) : 1'b1;
            if (mode == 2) start = (acc_cnt < 6);
            step();
            n++;
        end
        start = 1'b0; out_ready = 1'b1;
        chk("done_seen", done_cnt, 1);
        chk("beats", acc_cnt, 8);
        chk("last_count", last_cnt, 4);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_delay", done_cyc - last_acc_cyc, 2);
        if (mode != 1) chk("busy_cycles", busy_cnt, 8);
        for (int b = 0; b < 8 && b < log_q.size(); b++) begin
            chk("lit_a", log_q[b].a, la[b]);
            chk("lit_b", log_q[b].b, lb[b]);
            chk("lit_last", log_q[b].l, b % 2);
        end
        step(); step(); step();
        chk("single_done", done_cnt, 1);
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int n, nb, dn;
        rst_n = 1'b0;
        ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = 3'd0; ld_data = 32'd0;
        start = 1'b0; out_ready = 1'b0;
        k1_ld_valid = 1'b0; k1_ld_sel = 1'b0; k1_ld_addr = 1'b0; k1_ld_data = 32'd0;
        k1_start = 1'b0; k1_out_ready = 1'b1;
        step(); step();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", out_last, 0);
        chk("rst_a", data_a, 0);
        chk("rst_b", data_b, 0);
        chk("rst_drop", ld_drop, 0);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < KK; k++)
            for (int i = 0; i < MM; i++) load(1'b0, k*MM+i, 10*i+k);
        for (int j = 0; j < NN; j++)
            for (int k = 0; k < KK; k++) load(1'b1, j*KK+k, 100*j+k);

        run_stream(0);
        run_stream(1);
        run_stream(3);
        load(1'b0, 4, 555);
        load(1'b1, 4, 556);
        run_stream(0);
        run_stream(4);
        run_stream(2);

        // Reset in the middle of a stream.
        push_run();
        acc_cnt = 0; done_cnt = 0;
        start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (acc_cnt < 3 && n < 50) begin
            step();
            n++;
        end
        chk("rst_pre_beats", acc_cnt, 3);
        rst_n = 1'b0;
        #2;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        step(); step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_idle_valid", out_valid, 0);
        run_stream(0);

        // K = 1 instance: A^T address i, B^T address j.
        for (int i = 0; i < 2; i++) begin
            k1_ld_valid = 1'b1; k1_ld_sel = 1'b0; k1_ld_addr = 1'(i); k1_ld_data = 32'(10*i);
            step();
            chk("k1_ld_drop", k1_ld_drop, 0);
        end
        for (int j = 0; j < 2; j++) begin
            k1_ld_valid = 1'b1; k1_ld_sel = 1'b1; k1_ld_addr = 1'(j); k1_ld_data = 32'(100*j);
            step();
            chk("k1_ld_drop", k1_ld_drop, 0);
        end
        k1_ld_valid = 1'b0;
        k1_start = 1'b1;
        step();
        k1_start = 1'b0;
        nb = 0; dn = 0; n = 0;
        while (dn == 0 && n < 40) begin
            if (k1_out_valid) begin
                chk("k1_a", k1_data_a, 10 * (nb / 2));
                chk("k1_b", k1_data_b, 100 * (nb % 2));
                chk("k1_last", k1_out_last, 1);
                nb++;
            end
            if (k1_done) begin
                chk("k1_beats_before_done", nb, 4);
                dn++;
            end
            step();
            n++;
        end
        chk("k1_done_seen", dn, 1);
        chk("k1_beats", nb, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
